sprite_line_engine: RTL and testbench

Multi-sprite scanline renderer that generalises the single motion-sprite ping-pong line buffer to NUM_SPRITES prioritised sprites with parametrised pixel depth, line width and sprite size. During each display line it renders the next line into a back bank: clear, then draw every enabled sprite whose rows cover that line. The VGA path reads the front bank. It sits between the CPU I/O decode (sprite registers), a shared sprite-pattern ROM and the pixel mux ahead of the colour lookup.

---
 rtl/sprite_pkg.sv | 20 ++
 rtl/line_buffer_2bank.sv | 25 ++
 rtl/sprite_line_engine.sv | 239 +++++++++++++++++++++++
 tb/tb_sprite_line_engine.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite scanline renderer: FSM states,
// sprite register field codes and the transparent pixel value.
package sprite_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SCAN,
        DRAW,
        DONE
    } state_t;

    localparam logic [1:0] FLD_NUM = 2'd0;
    localparam logic [1:0] FLD_X   = 2'd1;
    localparam logic [1:0] FLD_Y   = 2'd2;
    localparam logic [1:0] FLD_EN  = 2'd3;

    localparam int unsigned TRANSPARENT = 0;

endpackage

// File: rtl/line_buffer_2bank.sv
// Two-bank scanline RAM: one write port, one registered read port.
// The address MSB selects the bank, the low bits select the pixel.
module line_buffer_2bank #(
    parameter int PIXEL_BITS = 2,
    parameter int LINE_WIDTH = 320,
    parameter int X_BITS     = 9
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [X_BITS:0]       wr_addr,
    input  logic [PIXEL_BITS-1:0] wr_data,
    input  logic [X_BITS:0]       rd_addr,
    output logic [PIXEL_BITS-1:0] rd_data
);

    logic [PIXEL_BITS-1:0] mem [0:1][0:LINE_WIDTH-1];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr[X_BITS]][wr_addr[X_BITS-1:0]] <= wr_data;
        end
        rd_data <= mem[rd_addr[X_BITS]][rd_addr[X_BITS-1:0]];
    end

endmodule

// File: rtl/sprite_line_engine.sv
// Multi-sprite scanline renderer: while the front bank is displayed, the
// back bank is cleared and every enabled sprite covering the next line drawn.
module sprite_line_engine
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int IDX_BITS    = 2,
    parameter int PIXEL_BITS  = 2,
    parameter int LINE_WIDTH  = 320,
    parameter int X_BITS      = 9,
    parameter int Y_BITS      = 10,
    parameter int SIZE_LOG2   = 3,
    parameter int NUM_BITS    = 6
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            line_start,
    input  logic [Y_BITS-1:0]               next_line_y,
    input  logic [X_BITS-1:0]               rd_x,
    output logic [PIXEL_BITS-1:0]           rd_pixel,
    input  logic                            reg_write,
    input  logic [IDX_BITS+1:0]             reg_addr,
    input  logic [Y_BITS-1:0]               reg_wr_data,
    output logic [NUM_BITS+2*SIZE_LOG2-1:0] rom_addr,
    input  logic [PIXEL_BITS-1:0]           rom_data,
    output logic                            busy,
    output logic                            overrun,
    input  logic                            overrun_clear,
    output logic [IDX_BITS:0]               hit_count
);

    logic [NUM_BITS-1:0]    spr_num [NUM_SPRITES];
    logic [X_BITS-1:0]      spr_x   [NUM_SPRITES];
    logic [Y_BITS-1:0]      spr_y   [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] spr_en;

    logic [IDX_BITS-1:0] reg_idx;
    logic [1:0]          reg_field;

    state_t state;
    state_t state_next;

    logic                 bank_sel;
    logic                 bank_valid;
    logic                 render_done;
    logic [Y_BITS-1:0]    line_y;
    logic [X_BITS-1:0]    clear_x;
    logic [IDX_BITS-1:0]  idx;
    logic [SIZE_LOG2:0]   col;
    logic [SIZE_LOG2-1:0] row;
    logic [NUM_BITS-1:0]  cur_num;
    logic [X_BITS-1:0]    cur_x;
    logic [IDX_BITS:0]    hits;
    logic                 wr_pending;
    logic [X_BITS:0]      wr_x;
    logic                 rd_ok;

    logic [Y_BITS-1:0]     dy;
    logic                  scan_hit;
    logic                  ram_we;
    logic [X_BITS:0]       ram_waddr;
    logic [PIXEL_BITS-1:0] ram_wdata;
    logic [PIXEL_BITS-1:0] ram_q;

    assign reg_idx   = reg_addr[IDX_BITS+1:2];
    assign reg_field = reg_addr[1:0];

    always_ff @(posedge clock) begin
        if (!reset) begin
            spr_num <= '{default: '0};
            spr_x   <= '{default: '0};
            spr_y   <= '{default: '0};
            spr_en  <= '0;
        end else if (reg_write) begin
            case (reg_field)
                FLD_NUM: spr_num[reg_idx] <= reg_wr_data[NUM_BITS-1:0];
                FLD_X:   spr_x[reg_idx]   <= reg_wr_data[X_BITS-1:0];
                FLD_Y:   spr_y[reg_idx]   <= reg_wr_data;
                default: spr_en[reg_idx]  <= reg_wr_data[0];
            endcase
        end
    end

    // Row offset wraps modulo 2^Y_BITS so sprites near the top edge reach line 0.
    assign dy       = line_y - spr_y[idx];
    assign scan_hit = spr_en[idx] && ((dy >> SIZE_LOG2) == '0);

    assign busy = (state == CLEAR) || (state == SCAN) || (state == DRAW);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: state_next = IDLE;
            CLEAR: begin
                if (clear_x == X_BITS'(LINE_WIDTH - 1)) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (scan_hit) begin
                    state_next = DRAW;
                end else if (idx == '0) begin
                    state_next = DONE;
                end
            end
            DRAW: begin
                if (col[SIZE_LOG2]) begin
                    state_next = (idx == '0) ? DONE : SCAN;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (line_start) begin
            state_next = CLEAR;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            bank_sel    <= 1'b0;
            bank_valid  <= 1'b0;
            render_done <= 1'b0;
            line_y      <= '0;
            clear_x     <= '0;
            idx         <= '0;
            col         <= '0;
            row         <= '0;
            cur_num     <= '0;
            cur_x       <= '0;
            hits        <= '0;
            hit_count   <= '0;
            wr_pending  <= 1'b0;
            wr_x        <= '0;
            overrun     <= 1'b0;
        end else begin
            wr_pending <= 1'b0;
            case (state)
                CLEAR: clear_x <= clear_x + 1'b1;
                SCAN: begin
                    if (scan_hit) begin
                        col     <= '0;
                        row     <= dy[SIZE_LOG2-1:0];
                        cur_num <= spr_num[idx];
                        cur_x   <= spr_x[idx];
                        hits    <= hits + 1'b1;
                    end else if (idx != '0) begin
                        idx <= idx - 1'b1;
                    end
                end
                DRAW: begin
                    if (!col[SIZE_LOG2]) begin
                        wr_pending <= 1'b1;
                        wr_x       <= {1'b0, cur_x} + (X_BITS + 1)'(col);
                        col        <= col + 1'b1;
                    end else if (idx != '0) begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    hit_count   <= hits;
                    render_done <= 1'b1;
                end
                default: ;
            endcase

            // A new line always wins: any in-flight render and its pending ROM write are dropped.
            if (line_start) begin
                bank_sel    <= ~bank_sel;
                bank_valid  <= bank_valid | render_done | (state == DONE);
                render_done <= 1'b0;
                line_y      <= next_line_y;
                clear_x     <= '0;
                idx         <= IDX_BITS'(NUM_SPRITES - 1);
                hits        <= '0;
                wr_pending  <= 1'b0;
            end

            if (line_start && busy) begin
                overrun <= 1'b1;
            end else if (overrun_clear) begin
                overrun <= 1'b0;
            end
        end
    end

    always_comb begin
        rom_addr = '0;
        if (state == DRAW && !col[SIZE_LOG2]) begin
            rom_addr = {cur_num, row, col[SIZE_LOG2-1:0]};
        end
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = {~bank_sel, clear_x};
        ram_wdata = PIXEL_BITS'(TRANSPARENT);
        if (state == CLEAR) begin
            ram_we = 1'b1;
        end else if (wr_pending && rom_data != PIXEL_BITS'(TRANSPARENT)
                     && wr_x < (X_BITS + 1)'(LINE_WIDTH)) begin
            ram_we    = 1'b1;
            ram_waddr = {~bank_sel, wr_x[X_BITS-1:0]};
            ram_wdata = rom_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ok <= 1'b0;
        end else begin
            rd_ok <= bank_valid && ({1'b0, rd_x} < (X_BITS + 1)'(LINE_WIDTH));
        end
    end

    assign rd_pixel = rd_ok ? ram_q : '0;

    line_buffer_2bank #(
        .PIXEL_BITS (PIXEL_BITS),
        .LINE_WIDTH (LINE_WIDTH),
        .X_BITS     (X_BITS)
    ) u_line_buffer (
        .clock   (clock),
        .wr_en   (ram_we),
        .wr_addr (ram_waddr),
        .wr_data (ram_wdata),
        .rd_addr ({bank_sel, rd_x}),
        .rd_data (ram_q)
    );

endmodule

// File: tb/tb_sprite_line_engine.sv
// Directed bench for sprite_line_engine with a behavioural sprite ROM.
module tb_sprite_line_engine;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        line_start = 1'b0;
    logic [9:0]  next_line_y = '0;
    logic [8:0]  rd_x = '0;
    logic [1:0]  rd_pixel;
    logic        reg_write = 1'b0;
    logic [3:0]  reg_addr = '0;
    logic [9:0]  reg_wr_data = '0;
    logic [11:0] rom_addr;
    logic [1:0]  rom_data = '0;
    logic        busy;
    logic        overrun;
    logic        overrun_clear = 1'b0;
    logic [2:0]  hit_count;

    int checks = 0;
    int failures = 0;
    int n;

    // Pattern 3 at row 2 is col ^ row: 2,3,0,1,2,3,0,1 (cols 2 and 6 transparent).
    logic [1:0] row2_pat [8] = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    sprite_line_engine dut (
        .clock         (clock),
        .reset         (reset),
        .line_start    (line_start),
        .next_line_y   (next_line_y),
        .rd_x          (rd_x),
        .rd_pixel      (rd_pixel),
        .reg_write     (reg_write),
        .reg_addr      (reg_addr),
        .reg_wr_data   (reg_wr_data),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .busy          (busy),
        .overrun       (overrun),
        .overrun_clear (overrun_clear),
        .hit_count     (hit_count)
    );

    always #5 clock = ~clock;

    function automatic logic [1:0] rom_model(input logic [11:0] a);
        logic [5:0] num;
        logic [2:0] r;
        logic [2:0] c;
        num = a[11:6];
        r   = a[5:3];
        c   = a[2:0];
        case (num)
            6'd1:    return (c == 3'd0) ? 2'd0 : 2'd1;
            6'd2:    return 2'd2;
            6'd3:    return c[1:0] ^ r[1:0];
            default: return 2'd3;
        endcase
    endfunction

    always @(posedge clock) rom_data <= rom_model(rom_addr);

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic write_reg(input int idx, input logic [1:0] fld, input int data);
        reg_write   = 1'b1;
        reg_addr    = {idx[1:0], fld};
        reg_wr_data = data[9:0];
        tick();
        reg_write   = 1'b0;
    endtask

    task automatic set_sprite(input int idx, input int num, input int x, input int y, input int en);
        write_reg(idx, 2'd0, num);
        write_reg(idx, 2'd1, x);
        write_reg(idx, 2'd2, y);
        write_reg(idx, 2'd3, en);
    endtask

    task automatic pulse_line(input int y);
        line_start  = 1'b1;
        next_line_y = y[9:0];
        tick();
        line_start  = 1'b0;
    endtask

    // Counts edges from the line_start edge (counted as 1) until busy is seen low.
    task automatic wait_idle(input string tag, output int cycles);
        cycles = 1;
        while (busy && cycles < 2000) begin
            tick();
            cycles++;
        end
        if (busy) check({tag, "_timeout"}, 32'(busy), 32'd0);
        tick();
    endtask

    task automatic read_px(input string tag, input int x, input int exp);
        rd_x = x[8:0];
        tick();
        check(tag, 32'(rd_pixel), 32'(exp));
    endtask

    initial begin
        // Reset
        repeat (2) tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_hit_count", 32'(hit_count), 0);
        check("rst_rom_addr", 32'(rom_addr), 0);
        reset = 1'b1;
        read_px("rst_px0", 0, 0);
        read_px("rst_px10", 10, 0);
        read_px("rst_px319", 319, 0);

        // Single sprite, row 2 of pattern 3 at x=10
        set_sprite(0, 3, 10, 5, 1);
        pulse_line(7);
        check("s1_busy", 32'(busy), 1);
        n = 0;
        while (rom_addr == '0 && n < 1000) begin
            tick();
            n++;
        end
        check("s1_rom_addr_c0", 32'(rom_addr), 32'd208);
        tick();
        check("s1_rom_addr_c1", 32'(rom_addr), 32'd209);
        wait_idle("s1_idle", n);
        check("s1_hit_count", 32'(hit_count), 1);
        read_px("s1_no_valid", 12, 0);
        pulse_line(300);
        for (int i = 0; i < 8; i++) read_px("s1_px", 10 + i, row2_pat[i]);
        read_px("s1_px9", 9, 0);
        read_px("s1_px18", 18, 0);
        read_px("s1_px0", 0, 0);
        read_px("s1_px400", 400, 0);
        wait_idle("s1b_idle", n);

        // Priority and transparency
        set_sprite(0, 1, 20, 0, 1);
        set_sprite(1, 2, 20, 0, 1);
        pulse_line(0);
        wait_idle("pr_idle", n);
        check("pr_cycles", 32'(n), 32'd343);
        check("pr_hit_count", 32'(hit_count), 2);
        pulse_line(300);
        read_px("pr_px19", 19, 0);
        read_px("pr_px20", 20, 2);
        for (int i = 21; i < 28; i++) read_px("pr_px", i, 1);
        read_px("pr_px28", 28, 0);
        read_px("pr_px12", 12, 0);
        wait_idle("pr_b_idle", n);

        // Right-edge clipping, no x wrap, and y wrap (line 2 vs y=1020 -> row 6)
        set_sprite(0, 2, 316, 1020, 1);
        set_sprite(1, 2, 510, 1020, 1);
        pulse_line(2);
        n = 0;
        while (rom_addr == '0 && n < 1000) begin
            tick();
            n++;
        end
        check("cl_rom_addr_row6", 32'(rom_addr), 32'd176);
        wait_idle("cl_idle", n);
        check("cl_hit_count", 32'(hit_count), 2);
        pulse_line(300);
        read_px("cl_px315", 315, 0);
        for (int i = 316; i < 320; i++) read_px("cl_px_edge", i, 2);
        for (int i = 0; i < 4; i++) read_px("cl_px_wrap", i, 0);
        read_px("cl_px20", 20, 0);
        wait_idle("cl_b_idle", n);

        // Disabled sprites: blank line, minimum render length
        write_reg(0, 2'd3, 0);
        write_reg(1, 2'd3, 0);
        pulse_line(2);
        wait_idle("dis_idle", n);
        check("dis_cycles", 32'(n), 32'd325);
        check("dis_hit_count", 32'(hit_count), 0);
        pulse_line(300);
        read_px("dis_px316", 316, 0);
        read_px("dis_px20", 20, 0);
        wait_idle("dis_b_idle", n);

        // Enabled but line outside sprite rows
        set_sprite(0, 3, 10, 5, 1);
        pulse_line(20);
        wait_idle("miss_idle", n);
        check("miss_cycles", 32'(n), 32'd325);
        check("miss_hit_count", 32'(hit_count), 0);
        pulse_line(300);
        read_px("miss_px12", 12, 0);
        wait_idle("miss_b_idle", n);

        // Overrun: restart mid-render, completed line still correct
        pulse_line(7);
        repeat (100) tick();
        check("ov_before", 32'(overrun), 0);
        check("ov_busy", 32'(busy), 1);
        pulse_line(7);
        check("ov_set", 32'(overrun), 1);
        wait_idle("ov_idle", n);
        check("ov_cycles", 32'(n), 32'd334);
        check("ov_sticky", 32'(overrun), 1);
        check("ov_hit_count", 32'(hit_count), 1);
        pulse_line(300);
        for (int i = 0; i < 8; i++) read_px("ov_px", 10 + i, row2_pat[i]);
        overrun_clear = 1'b1;
        tick();
        overrun_clear = 1'b0;
        check("ov_cleared", 32'(overrun), 0);
        wait_idle("ov_b_idle", n);
        check("ov_no_reset", 32'(overrun), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
